// File: rtl/udma_pkg.sv
// Shared constants for the uDMA event path: bus geometry and output ID width.
// The subsystem's event flattening and the serializer both use these values.
package udma_pkg;

    localparam int UDMA_N_PERIPH        = 32;
    localparam int UDMA_EVT_PER_PERIPH  = 4;
    localparam int UDMA_N_EVT           = UDMA_N_PERIPH * UDMA_EVT_PER_PERIPH;
    localparam int UDMA_EVT_ID_WIDTH    = 8;

    // Flattened line index of event `evt` belonging to peripheral `periph`.
    function automatic int udma_evt_line(input int periph, input int evt);
        return periph * UDMA_EVT_PER_PERIPH + evt;
    endfunction

endpackage

// File: rtl/udma_evt_serializer_if.sv
// Valid/ready stream carrying one event line index per handshake.
// The master drives valid and data; the slave answers with ready.
interface udma_evt_serializer_if #(
    parameter int ID_WIDTH = 8
);

    logic                evt_valid_o;
    logic [ID_WIDTH-1:0] evt_data_o;
    logic                evt_ready_i;

    modport master (
        output evt_valid_o,
        output evt_data_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_data_o,
        output evt_ready_i
    );

endinterface

// File: rtl/udma_evt_rr_arb.sv
// Combinational round-robin arbiter: the first request strictly after ptr_i wins,
// wrapping from N-1 to 0. Implemented as a masked priority encoder over {req, req}.
module udma_evt_rr_arb #(
    parameter  int N     = 128,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] win_mask;
    logic [2*N-1:0] req_masked;

    // The window ptr+1 .. ptr+N covers every line exactly once, so the lowest
    // set bit inside it is the next line in round-robin order.
    always_comb begin
        req_dbl  = {req_i, req_i};
        win_mask = '0;
        for (int j = 0; j < 2 * N; j++) begin
            win_mask[j] = (j > int'(ptr_i)) && (j <= int'(ptr_i) + N);
        end
        req_masked = req_dbl & win_mask;
    end

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (req_masked[j]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'((j >= N) ? (j - N) : j);
            end
        end
    end

endmodule

// File: rtl/udma_evt_serializer.sv
// Counts event pulses per line in saturating counters and streams pending line
// indices one per handshake in round-robin order; drops are flagged on lost_o.
module udma_evt_serializer
    import udma_pkg::*;
#(
    parameter  int N_EVT     = UDMA_N_EVT,
    parameter  int CNT_WIDTH = 2,
    parameter  int ID_WIDTH  = UDMA_EVT_ID_WIDTH,
    localparam int IDX_W     = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_resetn_i,
    input  logic [N_EVT-1:0]       events_i,
    udma_evt_serializer_if.master  evt_if,
    output logic                   lost_o,
    output logic                   pending_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0]     PTR_RESET = IDX_W'(N_EVT - 1);

    logic [CNT_WIDTH-1:0] cnt_q [N_EVT];
    logic [CNT_WIDTH-1:0] cnt_d [N_EVT];
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [ID_WIDTH-1:0]  data_q, data_d;
    logic                 lost_q, lost_d;

    logic [N_EVT-1:0]     req;
    logic [N_EVT-1:0]     inc;
    logic [N_EVT-1:0]     dec;
    logic                 gnt_valid;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 load;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_EVT; i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    udma_evt_rr_arb #(
        .N (N_EVT)
    ) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // The output register is free when empty or being drained this cycle.
    assign load = (!valid_q || evt_if.evt_ready_i) && gnt_valid;

    // A saturated line still accepts a pulse when it is being drained in the
    // same cycle; only a pulse with nowhere to go counts as lost.
    always_comb begin
        dec = '0;
        if (load) begin
            dec[gnt_idx] = 1'b1;
        end
        inc = '0;
        for (int i = 0; i < N_EVT; i++) begin
            inc[i]   = events_i[i] && ((cnt_q[i] != CNT_MAX) || dec[i]);
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(inc[i]) - CNT_WIDTH'(dec[i]);
        end
        lost_d = |(events_i & ~inc);
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            ptr_d   = gnt_idx;
            valid_d = 1'b1;
            data_d  = ID_WIDTH'(gnt_idx);
        end else if (evt_if.evt_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            for (int i = 0; i < N_EVT; i++) begin
                cnt_q[i] <= '0;
            end
            ptr_q   <= PTR_RESET;
            valid_q <= 1'b0;
            data_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_EVT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            lost_q  <= lost_d;
        end
    end

    assign evt_if.evt_valid_o = valid_q;
    assign evt_if.evt_data_o  = data_q;
    assign lost_o             = lost_q;
    assign pending_o          = (|req) || valid_q;

endmodule

// File: tb/tb_udma_evt_serializer.sv
// Directed bench for udma_evt_serializer: latency, round-robin order,
// backpressure, saturation/loss and asynchronous reset behaviour.
module tb_udma_evt_serializer;
    import udma_pkg::*;

    localparam int N   = UDMA_N_EVT;
    localparam int IDW = UDMA_EVT_ID_WIDTH;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] events = '0;
    logic         lost;
    logic         pending;

    int checks   = 0;
    int failures = 0;

    udma_evt_serializer_if #(.ID_WIDTH(IDW)) evt_if ();

    udma_evt_serializer dut (
        .sys_clk_i    (clk),
        .sys_resetn_i (rst_n),
        .events_i     (events),
        .evt_if       (evt_if),
        .lost_o       (lost),
        .pending_o    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        events = '0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        evt_if.evt_ready_i = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_if.evt_valid_o); end
        checks++; if (evt_if.evt_data_o !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", evt_if.evt_data_o); end
        checks++; if (lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", lost); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        evt_if.evt_ready_i = 1'b1;
        events[5] = 1'b1;
        tick();
        events = '0;
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", evt_if.evt_valid_o); end
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL single_pending got=%b exp=1", pending); end
        tick();
        checks++; if (evt_if.evt_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", evt_if.evt_valid_o); end
        checks++; if (evt_if.evt_data_o !== 8'd5) begin failures++; $display("FAIL single_data got=%0d exp=5", evt_if.evt_data_o); end
        tick();
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL single_drop_valid got=%b exp=0", evt_if.evt_valid_o); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL single_idle_pending got=%b exp=0", pending); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ids [3];
        exp_ids[0] = 8'd3;
        exp_ids[1] = 8'd40;
        exp_ids[2] = 8'd127;
        apply_reset();
        evt_if.evt_ready_i = 1'b1;
        events[3]   = 1'b1;
        events[40]  = 1'b1;
        events[127] = 1'b1;
        tick();
        events = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_data_o !== exp_ids[k]) begin
                failures++;
                $display("FAIL b2b_id%0d got valid=%b data=%0d exp valid=1 data=%0d", k, evt_if.evt_valid_o, evt_if.evt_data_o, exp_ids[k]);
            end
        end
        tick();
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", evt_if.evt_valid_o); end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_id;
        evt_if.evt_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            events = '0;
            events[k % 2] = 1'b1;
            tick();
            if (k >= 1) begin
                exp_id = 8'((k - 1) % 2);
                checks++;
                if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_data_o !== exp_id || lost !== 1'b0) begin
                    failures++;
                    $display("FAIL alt_cycle%0d got valid=%b data=%0d lost=%b exp valid=1 data=%0d lost=0", k, evt_if.evt_valid_o, evt_if.evt_data_o, lost, exp_id);
                end
            end
        end
        events = '0;
        tick();
        checks++; if (evt_if.evt_data_o !== 8'd1 || lost !== 1'b0) begin failures++; $display("FAIL alt_last got data=%0d lost=%b exp data=1 lost=0", evt_if.evt_data_o, lost); end
        tick();
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL alt_end_valid got=%b exp=0", evt_if.evt_valid_o); end
    endtask

    task automatic test_backpressure();
        evt_if.evt_ready_i = 1'b0;
        events[10] = 1'b1;
        tick();
        events = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_data_o !== 8'd10) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b data=%0d exp valid=1 data=10", k, evt_if.evt_valid_o, evt_if.evt_data_o);
            end
        end
        evt_if.evt_ready_i = 1'b1;
        tick();
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL bp_accept_valid got=%b exp=0", evt_if.evt_valid_o); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bp_pending got=%b exp=0", pending); end
    endtask

    task automatic test_saturation();
        int n7;
        int nlost;
        evt_if.evt_ready_i = 1'b0;
        events[20] = 1'b1;
        tick();
        events = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            events = '0;
            events[7] = 1'b1;
            tick();
            checks++;
            if (lost !== (k == 3)) begin
                failures++;
                $display("FAIL sat_lost_pulse%0d got=%b exp=%0d", k, lost, (k == 3));
            end
        end
        events = '0;
        tick();
        checks++; if (lost !== 1'b0) begin failures++; $display("FAIL sat_lost_single got=%b exp=0", lost); end
        checks++; if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_data_o !== 8'd20) begin failures++; $display("FAIL sat_head got valid=%b data=%0d exp valid=1 data=20", evt_if.evt_valid_o, evt_if.evt_data_o); end
        evt_if.evt_ready_i = 1'b1;
        n7    = 0;
        nlost = 0;
        repeat (6) begin
            tick();
            if (evt_if.evt_valid_o === 1'b1 && evt_if.evt_data_o === 8'd7) n7++;
            if (lost !== 1'b0) nlost++;
        end
        checks++; if (n7 != 3) begin failures++; $display("FAIL sat_emit_count got=%0d exp=3", n7); end
        checks++; if (nlost != 0) begin failures++; $display("FAIL sat_drain_lost got=%0d exp=0", nlost); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL sat_pending got=%b exp=0", pending); end
    endtask

    task automatic test_sat_with_dec();
        int n7;
        int nlost;
        evt_if.evt_ready_i = 1'b0;
        events[20] = 1'b1;
        tick();
        events = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            events = '0;
            events[7] = 1'b1;
            tick();
        end
        evt_if.evt_ready_i = 1'b1;
        tick();
        events = '0;
        checks++; if (lost !== 1'b0) begin failures++; $display("FAIL satdec_lost got=%b exp=0", lost); end
        checks++; if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_data_o !== 8'd7) begin failures++; $display("FAIL satdec_load got valid=%b data=%0d exp valid=1 data=7", evt_if.evt_valid_o, evt_if.evt_data_o); end
        n7    = 1;
        nlost = 0;
        repeat (5) begin
            tick();
            if (evt_if.evt_valid_o === 1'b1 && evt_if.evt_data_o === 8'd7) n7++;
            if (lost !== 1'b0) nlost++;
        end
        checks++; if (n7 != 4) begin failures++; $display("FAIL satdec_emit_count got=%0d exp=4", n7); end
        checks++; if (nlost != 0) begin failures++; $display("FAIL satdec_drain_lost got=%0d exp=0", nlost); end
    endtask

    task automatic test_reset_midop();
        int seen;
        evt_if.evt_ready_i = 1'b0;
        events[9] = 1'b1;
        tick();
        tick();
        events = '0;
        checks++; if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_data_o !== 8'd9) begin failures++; $display("FAIL midrst_pre got valid=%b data=%0d exp valid=1 data=9", evt_if.evt_valid_o, evt_if.evt_data_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (evt_if.evt_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", evt_if.evt_valid_o); end
        checks++; if (evt_if.evt_data_o !== 8'd0) begin failures++; $display("FAIL midrst_data got=%0d exp=0", evt_if.evt_data_o); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL midrst_pending got=%b exp=0", pending); end
        tick();
        rst_n = 1'b1;
        evt_if.evt_ready_i = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (evt_if.evt_valid_o !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_after got=%0d valid cycles exp=0", seen); end
    endtask

    initial begin
        evt_if.evt_ready_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_backpressure();
        test_saturation();
        test_sat_with_dec();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
